// File: rtl/ipm_distributed_fifo_sync.sv
// Single-clock FIFO on an inferred distributed-RAM array with count-based flags and standard/FWFT read.
// Optional sticky overflow/underflow outputs when DIST_FIFO_ERR_FLAG_EN is defined.
module ipm_distributed_fifo_sync #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          FWFT       = 1'b0,
    parameter int unsigned AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count
`ifdef DIST_FIFO_ERR_FLAG_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

    // Zero at power-up only; reset never clears the array.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count_next;
    logic                  wr_acc;
    logic                  rd_acc;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally; flags follow count_next so they line up with count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count        <= count_next;
            full         <= (count_next == FULL_LVL);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_LVL);
            almost_empty <= (count_next <= AE_LVL);
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign rd_data = mem[rd_ptr];
        end else begin : g_std
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data <= '0;
                end else if (rd_acc) begin
                    rd_data <= mem[rd_ptr];
                end
            end
        end
    endgenerate

`ifdef DIST_FIFO_ERR_FLAG_EN
    // Sticky request-error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ipm_distributed_fifo_sync.sv
// Scoreboard bench: standard and FWFT instances share stimulus; a monitor compares against a queue model.
module tb_ipm_distributed_fifo_sync;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;

    logic [7:0] rd_data_s, rd_data_f;
    logic       full_s, empty_s, af_s, ae_s;
    logic       full_f, empty_f, af_f, ae_f;
    logic [4:0] count_s, count_f;
`ifdef DIST_FIFO_ERR_FLAG_EN
    logic       ovf_s, unf_s, ovf_f, unf_f;
`endif

    ipm_distributed_fifo_sync #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(1'b0),
                                .AF_THRESH(14), .AE_THRESH(2)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
        .almost_empty(ae_s), .count(count_s)
`ifdef DIST_FIFO_ERR_FLAG_EN
        , .overflow(ovf_s), .underflow(unf_s)
`endif
    );

    ipm_distributed_fifo_sync #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(1'b1),
                                .AF_THRESH(14), .AE_THRESH(2)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
        .almost_empty(ae_f), .count(count_f)
`ifdef DIST_FIFO_ERR_FLAG_EN
        , .overflow(ovf_f), .underflow(unf_f)
`endif
    );

    typedef struct {
        logic [7:0] std_data;
        logic [7:0] head;
        logic       head_vld;
        logic [4:0] cnt;
        logic       fl, em, af, ae;
        logic       ovf, unf;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mq[$];
    logic [7:0] last_rd;
    logic       m_ovf, m_unf;
    int         vectors;
    int         miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.std_data = last_rd;
        e.head_vld = (mq.size() > 0);
        e.head     = (mq.size() > 0) ? mq[0] : 8'h00;
        e.cnt      = 5'(mq.size());
        e.fl       = (mq.size() == 16);
        e.em       = (mq.size() == 0);
        e.af       = (mq.size() >= 14);
        e.ae       = (mq.size() <= 2);
        e.ovf      = m_ovf;
        e.unf      = m_unf;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; the model state after the next rising edge is queued.
    task automatic step(input logic wr, input logic [7:0] d, input logic rd);
        logic wacc, racc;
        @(negedge clk);
        rst_n   = 1'b1;
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        wacc = wr && (mq.size() < 16);
        racc = rd && (mq.size() > 0);
        if (wr && mq.size() == 16) m_ovf = 1'b1;
        if (rd && mq.size() == 0)  m_unf = 1'b1;
        if (racc) last_rd = mq.pop_front();
        if (wacc) mq.push_back(d);
        push_exp();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        mq.delete();
        last_rd = 8'h00;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        push_exp();
    endtask

    // Monitor: compares both instances against the queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("std_rd_data", 32'(rd_data_s), 32'(e.std_data));
                chk("std_count",   32'(count_s),   32'(e.cnt));
                chk("std_full",    32'(full_s),    32'(e.fl));
                chk("std_empty",   32'(empty_s),   32'(e.em));
                chk("std_afull",   32'(af_s),      32'(e.af));
                chk("std_aempty",  32'(ae_s),      32'(e.ae));
                chk("fwft_count",  32'(count_f),   32'(e.cnt));
                chk("fwft_empty",  32'(empty_f),   32'(e.em));
                chk("fwft_full",   32'(full_f),    32'(e.fl));
                if (e.head_vld) chk("fwft_head", 32'(rd_data_f), 32'(e.head));
`ifdef DIST_FIFO_ERR_FLAG_EN
                chk("overflow",  32'(ovf_s), 32'(e.ovf));
                chk("underflow", 32'(unf_s), 32'(e.unf));
                chk("fwft_overflow", 32'(ovf_f), 32'(e.ovf));
`endif
            end
        end
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = 8'h00;
        last_rd = 8'h00;
        m_ovf = 1'b0;
        m_unf = 1'b0;

        do_reset();
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Fill to full, then a dropped 17th write.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Drain 0x00..0x0F, then a read while empty holds rd_data.
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Wrap: pointers advance past the last address.
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

        // Simultaneous accesses at full, empty and mid-level.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h3C, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
        step(1'b1, 8'h99, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

        // FWFT head visible without rd_en, then popped.
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Reset in the middle of a burst.
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        do_reset();
        step(1'b1, 8'h77, 1'b0);
        step(1'b1, 8'h78, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #3;
        vectors++;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
